// File: rtl/mem_arbiter_if.sv
// Requester, memory and status signals of the two-port memory arbiter.
// master = requesters/memory side, slave = arbiter side.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
);
  logic                  req0;
  logic                  we0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] wdata0;
  logic                  ack0;
  logic [DATA_WIDTH-1:0] rdata0;
  logic                  req1;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  ack1;
  logic [DATA_WIDTH-1:0] rdata1;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [DATA_WIDTH-1:0] mem_out;
  logic                  busy;
  logic                  owner;

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_out,
    input  ack0, rdata0, ack1, rdata1,
    input  mem_we, mem_addr, mem_data,
    input  busy, owner
  );

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_out,
    output ack0, rdata0, ack1, rdata1,
    output mem_we, mem_addr, mem_data,
    output busy, owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin sequencer for one single-port sync memory.
// MEM_ARBITER_FIXED_PRIO_EN selects fixed priority for requester 0.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0]            state_q, state_d;
  logic                  sel_q, sel_d;
  logic                  we_q, we_d;
  logic                  owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic                  idle_go, idle_pick;
  logic                  resp_go, resp_pick;
  logic                  go, pick;

  always_comb begin
    idle_go = bus.req0 | bus.req1;
`ifdef MEM_ARBITER_FIXED_PRIO_EN
    idle_pick = ~bus.req0;
    resp_go   = bus.req0 | bus.req1;
    resp_pick = ~bus.req0;
`else
    idle_pick = (bus.req0 & bus.req1) ? ~owner_q : bus.req1;
    // the requester just served sits out the RESP arbitration
    resp_go   = sel_q ? bus.req0 : bus.req1;
    resp_pick = ~sel_q;
`endif
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    we_d     = we_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    go       = 1'b0;
    pick     = 1'b0;
    unique case (state_q)
      IDLE: begin
        go   = idle_go;
        pick = idle_pick;
      end
      ACCESS: state_d = WAIT;
      WAIT: begin
        state_d = RESP;
        if (!we_q) begin
          if (sel_q) rdata1_d = bus.mem_out;
          else       rdata0_d = bus.mem_out;
        end
      end
      RESP: begin
        state_d = IDLE;
        go      = resp_go;
        pick    = resp_pick;
      end
      default: state_d = IDLE;
    endcase
    if (go) begin
      state_d = ACCESS;
      sel_d   = pick;
      owner_d = pick;
      we_d    = pick ? bus.we1    : bus.we0;
      addr_d  = pick ? bus.addr1  : bus.addr0;
      wdata_d = pick ? bus.wdata1 : bus.wdata0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= 1'b0;
      we_q     <= 1'b0;
      owner_q  <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // mem_we decodes from state so reset kills it at once
  assign bus.mem_we   = (state_q == ACCESS) & we_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_data = wdata_q;
  assign bus.ack0     = (state_q == RESP) & ~sel_q;
  assign bus.ack1     = (state_q == RESP) & sel_q;
  assign bus.rdata0   = rdata0_q;
  assign bus.rdata1   = rdata1_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.owner    = owner_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a
// transaction-level model and a behavioural memory.
module tb_mem_arbiter;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  mem_arbiter_if #(.ADDR_WIDTH(6), .DATA_WIDTH(16)) bus ();

  mem_arbiter #(.ADDR_WIDTH(6), .DATA_WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // the memory instance the arbiter drives
  logic [15:0] mem [64];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_data;
    bus.mem_out <= mem[bus.mem_addr];
  end

  // model: a granted transaction is age 1..3 (access, wait, ack)
  int          m_age;
  logic        m_sel, m_we, m_owner;
  logic [5:0]  m_addr;
  logic [15:0] m_wd;
  logic [15:0] m_rd0, m_rd1;
  logic [15:0] ref_mem [64];
  logic        m_r0, m_r1, m_w;

  always_comb begin
`ifdef MEM_ARBITER_FIXED_PRIO_EN
    m_r0 = bus.req0;
    m_r1 = bus.req1;
    m_w  = !m_r0;
`else
    m_r0 = bus.req0 && !(m_age == 3 && m_sel == 1'b0);
    m_r1 = bus.req1 && !(m_age == 3 && m_sel == 1'b1);
    m_w  = (m_r0 && m_r1) ? !m_owner : m_r1;
`endif
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_age   <= 0;
      m_sel   <= 1'b0;
      m_we    <= 1'b0;
      m_owner <= 1'b1;
      m_addr  <= '0;
      m_wd    <= '0;
      m_rd0   <= '0;
      m_rd1   <= '0;
    end else if (m_age == 1) begin
      if (m_we) ref_mem[m_addr] <= m_wd;
      m_age <= 2;
    end else if (m_age == 2) begin
      if (!m_we && !m_sel) m_rd0 <= ref_mem[m_addr];
      if (!m_we && m_sel)  m_rd1 <= ref_mem[m_addr];
      m_age <= 3;
    end else if (m_r0 || m_r1) begin
      m_age   <= 1;
      m_sel   <= m_w;
      m_owner <= m_w;
      m_we    <= m_w ? bus.we1    : bus.we0;
      m_addr  <= m_w ? bus.addr1  : bus.addr0;
      m_wd    <= m_w ? bus.wdata1 : bus.wdata0;
    end else begin
      m_age <= 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("busy", 32'(bus.busy), 32'(m_age != 0));
    chk("ack0", 32'(bus.ack0), 32'(m_age == 3 && !m_sel));
    chk("ack1", 32'(bus.ack1), 32'(m_age == 3 && m_sel));
    chk("mem_we", 32'(bus.mem_we), 32'(m_age == 1 && m_we));
    chk("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
    chk("mem_data", 32'(bus.mem_data), 32'(m_wd));
    chk("owner", 32'(bus.owner), 32'(m_owner));
    chk("rdata0", 32'(bus.rdata0), 32'(m_rd0));
    chk("rdata1", 32'(bus.rdata1), 32'(m_rd1));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [5:0] a, input logic [15:0] d);
    mem[a]     <= d;
    ref_mem[a] <= d;
  endtask

  initial begin
    int n;
    logic [15:0] old;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
    for (int i = 0; i < 64; i++) poke(6'(i), 16'($urandom));
    step(); step();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_owner", 32'(bus.owner), 32'd1);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    rst_n = 1'b1;
    step();

    // single read of a preloaded word
    poke(6'd5, 16'hABCD);
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 6'd5;
    step();
    chk("rd_access_busy", 32'(bus.busy), 32'd1);
    chk("rd_access_we", 32'(bus.mem_we), 32'd0);
    bus.req0 = 0;
    step();
    chk("rd_wait_ack", 32'(bus.ack0), 32'd0);
    step();
    chk("rd_ack0", 32'(bus.ack0), 32'd1);
    chk("rd_rdata0", 32'(bus.rdata0), 32'hABCD);
    step();
    chk("rd_ack_gone", 32'(bus.ack0), 32'd0);
    chk("rd_idle", 32'(bus.busy), 32'd0);

    // write by requester 1, read back by requester 0
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 6'd9; bus.wdata1 = 16'h1234;
    step();
    chk("wr_we", 32'(bus.mem_we), 32'd1);
    chk("wr_addr", 32'(bus.mem_addr), 32'd9);
    chk("wr_data", 32'(bus.mem_data), 32'h1234);
    bus.req1 = 0;
    step();
    chk("wr_we_once", 32'(bus.mem_we), 32'd0);
    step();
    chk("wr_ack1", 32'(bus.ack1), 32'd1);
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 6'd9;
    step();
    bus.req0 = 0;
    step();
    step();
    chk("rb_ack0", 32'(bus.ack0), 32'd1);
    chk("rb_rdata0", 32'(bus.rdata0), 32'h1234);
    chk("rb_rdata1", 32'(bus.rdata1), 32'd0);
    step();

    // both requesters held from reset: strict alternation
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 6'd5;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 6'd9;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k % 3 == 0) begin
        chk("rr_ack0", 32'(bus.ack0), 32'(((k / 3) % 2) == 1));
        chk("rr_ack1", 32'(bus.ack1), 32'(((k / 3) % 2) == 0));
      end else begin
        chk("rr_no_ack", 32'(bus.ack0 | bus.ack1), 32'd0);
      end
      if (k % 3 == 1)
        chk("rr_owner", 32'(bus.owner), 32'(((k - 1) / 3) % 2));
    end
    bus.req0 = 0; bus.req1 = 0;
    repeat (4) step();

    // address change after latching is ignored
    poke(6'd3, 16'h1111);
    poke(6'd7, 16'h7777);
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 6'd3;
    step();
    bus.req0 = 0; bus.addr0 = 6'd7;
    n = 0;
    for (int i = 1; i <= 5; i++) begin
      step();
      if (bus.ack0) n++;
      if (i == 2) chk("hold_rdata0", 32'(bus.rdata0), 32'h1111);
    end
    chk("hold_ack_count", 32'(n), 32'd1);

    // reset during the access cycle of a write
    old = mem[12];
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 6'd12; bus.wdata0 = 16'hBEEF;
    step();
    chk("rw_we_before", 32'(bus.mem_we), 32'd1);
    rst_n = 1'b0;
    bus.req0 = 0;
    #1;
    chk("rw_we_killed", 32'(bus.mem_we), 32'd0);
    chk("rw_busy", 32'(bus.busy), 32'd0);
    chk("rw_rdata0", 32'(bus.rdata0), 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("rw_mem_kept", 32'(mem[12]), 32'(old));
    bus.req0 = 1; bus.we0 = 0;
    step();
    bus.req0 = 0;
    step(); step();
    chk("rw_after_ack", 32'(bus.ack0), 32'd1);
    chk("rw_after_rd", 32'(bus.rdata0), 32'(old));
    step();

    // random traffic with occasional resets
    for (int c = 0; c < 4000; c++) begin
      bus.req0   = ($urandom_range(0, 3) != 0);
      bus.req1   = ($urandom_range(0, 2) != 0);
      bus.we0    = 1'($urandom);
      bus.we1    = 1'($urandom);
      bus.addr0  = 6'($urandom_range(0, 15));
      bus.addr1  = 6'($urandom_range(0, 15));
      bus.wdata0 = 16'($urandom);
      bus.wdata1 = 16'($urandom);
      rst_n      = ($urandom_range(0, 299) != 0);
      step();
    end
    rst_n = 1'b1;
    bus.req0 = 0; bus.req1 = 0;
    repeat (5) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
